// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: data width, parity, stop bits, valid/ready holding register.
// Define UART_RX_BREAK_DETECT_EN to add break detection (breakDet output, BREAK state).
module uart_rx_cfg #(
  parameter int Oversample = 16,
  parameter int DataWidth  = 8,
  parameter int Parity     = 0,
  parameter int StopBits   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in,
  output logic [DataWidth-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parityErr,
  output logic                 frameErr,
  output logic                 overrun,
  output logic                 busy
`ifdef UART_RX_BREAK_DETECT_EN
  ,
  output logic                 breakDet
`endif
);

  localparam int CW = $clog2(Oversample);
  localparam int BW = $clog2(DataWidth);
  localparam logic [CW-1:0] CntMid   = CW'(Oversample / 2 - 1);
  localparam logic [CW-1:0] CntEnd   = CW'(Oversample - 1);
  localparam logic [BW-1:0] BitLast  = BW'(DataWidth - 1);
  localparam logic [BW-1:0] StopLast = BW'(StopBits - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
`ifdef UART_RX_BREAK_DETECT_EN
    S_BREAK  = 3'd5,
`endif
    S_STOP   = 3'd4
  } state_e;

  function automatic logic exp_parity(input logic [DataWidth-1:0] w);
    if (Parity == 2) begin
      return ~^w;
    end else begin
      return ^w;
    end
  endfunction

  state_e                 state_q, state_d;
  logic                   sync1_q, sync_q, sync_prev_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_idx_q, bit_idx_d;
  logic [DataWidth-1:0]   shift_q, shift_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic [DataWidth-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   perr_out_q, perr_out_d;
  logic                   ferr_out_q, ferr_out_d;
  logic                   ovr_q, ovr_d;
  logic                   busy_q;
  logic                   fall_s;
  logic                   commit_s;
`ifdef UART_RX_BREAK_DETECT_EN
  logic                   zero_q, zero_d;
  logic                   brk_q, brk_d;
`endif

  assign fall_s = sync_prev_q && !sync_q;

  // Next-state, datapath and holding-register logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CW'(1);
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    data_d     = data_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    ovr_d      = 1'b0;
    commit_s   = 1'b0;
    valid_d    = valid_q && !ready;
`ifdef UART_RX_BREAK_DETECT_EN
    zero_d     = zero_q;
    brk_d      = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fall_s) begin
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (cnt_q == CntMid) begin
          cnt_d = '0;
          if (sync_q) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_idx_d = '0;
            perr_d    = 1'b0;
            ferr_d    = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            zero_d    = 1'b1;
`endif
          end
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (cnt_q == CntEnd) begin
          cnt_d   = '0;
          shift_d = {sync_q, shift_q[DataWidth-1:1]};
`ifdef UART_RX_BREAK_DETECT_EN
          zero_d  = zero_q && !sync_q;
`endif
          if (bit_idx_q == BitLast) begin
            bit_idx_d = '0;
            state_d   = (Parity != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + BW'(1);
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_PARITY: begin
        if (cnt_q == CntEnd) begin
          cnt_d   = '0;
          perr_d  = (sync_q != exp_parity(shift_q));
          state_d = S_STOP;
`ifdef UART_RX_BREAK_DETECT_EN
          zero_d  = zero_q && !sync_q;
`endif
        end else begin
          state_d = S_PARITY;
        end
      end
      S_STOP: begin
        if (cnt_q == CntEnd) begin
          cnt_d = '0;
          if (!sync_q) begin
            ferr_d = 1'b1;
          end else begin
            ferr_d = ferr_q;
          end
`ifdef UART_RX_BREAK_DETECT_EN
          // All-zero frame through the first stop bit is a break, never committed.
          if ((bit_idx_q == '0) && zero_q && !sync_q) begin
            state_d = S_BREAK;
            brk_d   = 1'b1;
          end else if (bit_idx_q == StopLast) begin
`else
          if (bit_idx_q == StopLast) begin
`endif
            commit_s = 1'b1;
            state_d  = S_IDLE;
          end else begin
            bit_idx_d = bit_idx_q + BW'(1);
          end
        end else begin
          state_d = S_STOP;
        end
      end
`ifdef UART_RX_BREAK_DETECT_EN
      S_BREAK: begin
        if (sync_q) begin
          if (cnt_q == CntEnd) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = '0;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Dequeue has already been applied to valid_d, so a same-cycle dequeue frees the slot.
    if (commit_s) begin
      if (!valid_d) begin
        data_d     = shift_q;
        perr_out_d = perr_d;
        ferr_out_d = ferr_d;
        valid_d    = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else begin
      ovr_d = 1'b0;
    end
  end

  // State, synchroniser and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync_q      <= 1'b1;
      sync_prev_q <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      perr_out_q  <= 1'b0;
      ferr_out_q  <= 1'b0;
      ovr_q       <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      zero_q      <= 1'b0;
      brk_q       <= 1'b0;
`endif
    end else begin
      sync1_q     <= in;
      sync_q      <= sync1_q;
      sync_prev_q <= sync_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      perr_out_q  <= perr_out_d;
      ferr_out_q  <= ferr_out_d;
      ovr_q       <= ovr_d;
      busy_q      <= (state_d != S_IDLE);
`ifdef UART_RX_BREAK_DETECT_EN
      zero_q      <= zero_d;
      brk_q       <= brk_d;
`endif
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign parityErr = perr_out_q;
  assign frameErr  = ferr_out_q;
  assign overrun   = ovr_q;
  assign busy      = busy_q;
`ifdef UART_RX_BREAK_DETECT_EN
  assign breakDet  = brk_q;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8N1, 7E1 and 8N2 instances on one clock.
module tb_uart_rx_cfg;
  localparam int OS = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic rx_line;
  int   sel;
  int   n_cmp = 0;
  int   n_err = 0;

  logic in_def, in_par, in_s2;
  assign in_def = (sel == 0) ? rx_line : 1'b1;
  assign in_par = (sel == 1) ? rx_line : 1'b1;
  assign in_s2  = (sel == 2) ? rx_line : 1'b1;

  logic [7:0] d_data;
  logic       d_valid, d_ready, d_perr, d_ferr, d_ovr, d_busy;
  logic [6:0] p_data;
  logic       p_valid, p_perr, p_ferr, p_ovr, p_busy;
  logic       p_ready = 1'b1;
  logic [7:0] s_data;
  logic       s_valid, s_perr, s_ferr, s_ovr, s_busy;
  logic       s_ready = 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
  logic       d_brk, p_brk, s_brk;
`endif

  uart_rx_cfg u_def (
    .clk(clk), .reset(reset), .in(in_def), .data(d_data), .valid(d_valid), .ready(d_ready),
    .parityErr(d_perr), .frameErr(d_ferr), .overrun(d_ovr), .busy(d_busy)
`ifdef UART_RX_BREAK_DETECT_EN
    , .breakDet(d_brk)
`endif
  );

  uart_rx_cfg #(.Oversample(OS), .DataWidth(7), .Parity(1), .StopBits(1)) u_par (
    .clk(clk), .reset(reset), .in(in_par), .data(p_data), .valid(p_valid), .ready(p_ready),
    .parityErr(p_perr), .frameErr(p_ferr), .overrun(p_ovr), .busy(p_busy)
`ifdef UART_RX_BREAK_DETECT_EN
    , .breakDet(p_brk)
`endif
  );

  uart_rx_cfg #(.Oversample(OS), .DataWidth(8), .Parity(0), .StopBits(2)) u_s2 (
    .clk(clk), .reset(reset), .in(in_s2), .data(s_data), .valid(s_valid), .ready(s_ready),
    .parityErr(s_perr), .frameErr(s_ferr), .overrun(s_ovr), .busy(s_busy)
`ifdef UART_RX_BREAK_DETECT_EN
    , .breakDet(s_brk)
`endif
  );

  // Observed transfers, recorded at the handshake so flags are seen with their word.
  logic [7:0] d_cap = 8'h00;
  logic       d_capp = 1'b0, d_capf = 1'b0;
  int         d_deq = 0, d_vcyc = 0, d_novr = 0, d_nbrk = 0;
  logic [6:0] p_cap = 7'h00;
  logic       p_capp = 1'b0, p_capf = 1'b0;
  int         p_deq = 0;
  logic [7:0] s_cap = 8'h00;
  logic       s_capp = 1'b0, s_capf = 1'b0;
  int         s_deq = 0;

  always @(posedge clk) begin
    if (d_valid && d_ready) begin
      d_cap  <= d_data;
      d_capp <= d_perr;
      d_capf <= d_ferr;
      d_deq  <= d_deq + 1;
    end
    if (d_valid) d_vcyc <= d_vcyc + 1;
    if (d_ovr)   d_novr <= d_novr + 1;
`ifdef UART_RX_BREAK_DETECT_EN
    if (d_brk)   d_nbrk <= d_nbrk + 1;
`endif
  end

  always @(posedge clk) begin
    if (p_valid && p_ready) begin
      p_cap  <= p_data;
      p_capp <= p_perr;
      p_capf <= p_ferr;
      p_deq  <= p_deq + 1;
    end
    if (s_valid && s_ready) begin
      s_cap  <= s_data;
      s_capp <= s_perr;
      s_capf <= s_ferr;
      s_deq  <= s_deq + 1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start bit, then n bits LSB first, then line back to idle.
  task automatic send(input logic [15:0] bits, input int n);
    rx_line = 1'b0;
    cyc(OS);
    for (int i = 0; i < n; i++) begin
      rx_line = bits[i];
      cyc(OS);
    end
    rx_line = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] w;
  int         exp_deq_final;

  initial begin
    reset   = 1'b1;
    rx_line = 1'b1;
    sel     = 0;
    d_ready = 1'b1;
    cyc(4);
    chk("rst_d_valid", 32'(d_valid), 32'd0);
    chk("rst_d_data",  32'(d_data),  32'd0);
    chk("rst_d_busy",  32'(d_busy),  32'd0);
    chk("rst_d_ovr",   32'(d_ovr),   32'd0);
    chk("rst_d_flags", 32'({d_perr, d_ferr}), 32'd0);
    chk("rst_p_valid", 32'(p_valid), 32'd0);
    chk("rst_s_valid", 32'(s_valid), 32'd0);
    reset = 1'b0;
    cyc(4);

    // 8N1 0xA5 with ready high
    send({7'h00, 1'b1, 8'hA5}, 9);
    cyc(20);
    chk("t1_deq",   32'(d_deq),  32'd1);
    chk("t1_data",  32'(d_cap),  32'hA5);
    chk("t1_perr",  32'(d_capp), 32'd0);
    chk("t1_ferr",  32'(d_capf), 32'd0);
    chk("t1_vcyc",  32'(d_vcyc), 32'd1);
    chk("t1_busy",  32'(d_busy), 32'd0);

    // 7E1 0x13: wrong parity bit, then correct one
    sel = 1;
    send({7'h00, 1'b1, 1'b0, 7'h13}, 9);
    cyc(20);
    chk("t2a_deq",  32'(p_deq),  32'd1);
    chk("t2a_data", 32'(p_cap),  32'h13);
    chk("t2a_perr", 32'(p_capp), 32'd1);
    chk("t2a_ferr", 32'(p_capf), 32'd0);
    send({7'h00, 1'b1, 1'b1, 7'h13}, 9);
    cyc(20);
    chk("t2b_deq",  32'(p_deq),  32'd2);
    chk("t2b_data", 32'(p_cap),  32'h13);
    chk("t2b_perr", 32'(p_capp), 32'd0);

    // 8N2: second stop bit low, then a clean 0xFF
    sel = 2;
    send({6'h00, 1'b0, 1'b1, 8'h3C}, 10);
    cyc(20);
    chk("t3a_deq",  32'(s_deq),  32'd1);
    chk("t3a_data", 32'(s_cap),  32'h3C);
    chk("t3a_ferr", 32'(s_capf), 32'd1);
    chk("t3a_perr", 32'(s_capp), 32'd0);
    send({6'h00, 2'b11, 8'hFF}, 10);
    cyc(20);
    chk("t3b_deq",  32'(s_deq),  32'd2);
    chk("t3b_data", 32'(s_cap),  32'hFF);
    chk("t3b_ferr", 32'(s_capf), 32'd0);

    // Overrun: two frames back-to-back with ready low
    sel = 0;
    d_ready = 1'b0;
    send({7'h00, 1'b1, 8'h11}, 9);
    send({7'h00, 1'b1, 8'h22}, 9);
    cyc(20);
    chk("t4_valid", 32'(d_valid), 32'd1);
    chk("t4_data",  32'(d_data),  32'h11);
    chk("t4_novr",  32'(d_novr),  32'd1);
    chk("t4_deq0",  32'(d_deq),   32'd1);
    d_ready = 1'b1;
    cyc(1);
    chk("t4_vdrop", 32'(d_valid), 32'd0);
    chk("t4_cap",   32'(d_cap),   32'h11);
    chk("t4_deq1",  32'(d_deq),   32'd2);
    cyc(50);
    chk("t4_no22",  32'(d_deq),   32'd2);

    // Start-bit glitch: 3 cycles low
    rx_line = 1'b0;
    cyc(3);
    rx_line = 1'b1;
    cyc(2);
    chk("t5_gbusy",  32'(d_busy),  32'd1);
    cyc(30);
    chk("t5_gidle",  32'(d_busy),  32'd0);
    chk("t5_gvalid", 32'(d_valid), 32'd0);
    chk("t5_gflags", 32'({d_perr, d_ferr, d_novr == 1}), 32'd1);

    // Held word, then reset in the middle of bit 4 of the next frame
    d_ready = 1'b0;
    send({7'h00, 1'b1, 8'h33}, 9);
    cyc(5);
    chk("t5_hvalid", 32'(d_valid), 32'd1);
    chk("t5_hdata",  32'(d_data),  32'h33);
    w = 8'h5A;
    rx_line = 1'b0;
    cyc(OS);
    for (int i = 0; i < 4; i++) begin
      rx_line = w[i];
      cyc(OS);
    end
    rx_line = w[4];
    cyc(8);
    chk("t5_mbusy", 32'(d_busy), 32'd1);
    reset   = 1'b1;
    rx_line = 1'b1;
    cyc(2);
    chk("t5_rvalid", 32'(d_valid), 32'd0);
    chk("t5_rdata",  32'(d_data),  32'd0);
    chk("t5_rbusy",  32'(d_busy),  32'd0);
    chk("t5_rflags", 32'({d_perr, d_ferr, d_ovr}), 32'd0);
    reset   = 1'b0;
    d_ready = 1'b1;
    cyc(5);
    send({7'h00, 1'b1, 8'h5A}, 9);
    cyc(20);
    chk("t5_deq",  32'(d_deq),  32'd3);
    chk("t5_data", 32'(d_cap),  32'h5A);
    chk("t5_ferr", 32'(d_capf), 32'd0);

`ifdef UART_RX_BREAK_DETECT_EN
    // Line low for 12 bit times
    rx_line = 1'b0;
    cyc(12 * OS);
    chk("t6_nbrk",  32'(d_nbrk),  32'd1);
    chk("t6_valid", 32'(d_valid), 32'd0);
    chk("t6_deq",   32'(d_deq),   32'd3);
    rx_line = 1'b1;
    cyc(OS + 6);
    chk("t6_idle",  32'(d_busy),  32'd0);
    exp_deq_final = 4;
`else
    // All-zero frame is delivered with a frame error
    send({7'h00, 1'b0, 8'h00}, 9);
    cyc(20);
    chk("t6_deq",   32'(d_deq),  32'd4);
    chk("t6_data",  32'(d_cap),  32'h00);
    chk("t6_ferr",  32'(d_capf), 32'd1);
    exp_deq_final = 5;
`endif
    send({7'h00, 1'b1, 8'h81}, 9);
    cyc(20);
    chk("t6_ndeq",  32'(d_deq),  32'(exp_deq_final));
    chk("t6_ndata", 32'(d_cap),  32'h81);
    chk("t6_nferr", 32'(d_capf), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
